my_sync_fifo: RTL and testbench
===============================

# my_sync_fifo

Single-clock, parameterised FIFO built on inferred storage, with no vendor primitive. It generalises the subsystem's fixed-geometry FIFO to arbitrary width and power-of-two depth. It adds programmable almost-full and almost-empty thresholds, an exact occupancy count, per-cycle error flags and optional first-word-fall-through. It sits between same-clock producers and consumers, such as UART/SPI shims and the Minion peripheral bus.

## Interface

Parameters:
- WIDTH, 9: data width in bits, 1..64.
- DEPTH_LOG2, 4: log2 of the entry count. DEPTH = 2**DEPTH_LOG2, with range 4..4096.
- AFULL_OFFSET, 2: almostfull asserts when count >= DEPTH-AFULL_OFFSET. Range 1..DEPTH-1.
- AEMPTY_OFFSET, 2: almostempty asserts when count <= AEMPTY_OFFSET. Range 1..DEPTH-1.

Ports:
- clk  in  1  the single clock. All logic is on the rising edge.
- rstn  in  1  synchronous reset, active-low.
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- dout  out  WIDTH  read data.
- dout_valid  out  1  dout holds a freshly read word (see Operation).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almostfull  out  1  threshold flag.
- almostempty  out  1  threshold flag.
- count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- wrerr  out  1  the previous cycle's write was rejected.
- rderr  out  1  the previous cycle's read was rejected.

## Operation

Pointers and count:
- Write and read pointers are DEPTH_LOG2 bits wide and wrap naturally from DEPTH-1 to 0.
- count is a separate register:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both are accepted, or when neither is.

Acceptance rules:
- A write is accepted when wr_en=1 and (full=0 or the read is accepted in the same cycle).
- A read is accepted when rd_en=1 and empty=0.
  - A read never consumes the word being written in the same cycle.
- A rejected request:
  - Changes no pointer, count or storage.
  - Sets wrerr or rderr to 1 for exactly the next cycle.
  - Does not affect the other request in the same cycle.

Flags:
- full, empty, almostfull and almostempty are registered.
- Each is computed from the next-state count, so it is always consistent with count in the same cycle.

Read data:
- dout behaviour depends on the mode; see Configuration.

Reset (rstn=0 at an edge):
- Pointers and count go to 0 and storage contents are discarded.
- Output values during reset:
  - empty=1, almostempty=1.
  - full=0, almostfull=0.
  - dout=0, dout_valid=0.
  - wrerr=0, rderr=0.
- wr_en and rd_en are ignored during reset.
- A reset mid-burst takes effect at that edge; no partial word is retained.

## Timing

- Write accepted at edge N:
  - count, empty and the thresholds reflect it from edge N.
  - The word is readable by a read request sampled at edge N+1.
- Read latency:
  - Standard mode: 1 cycle. A read accepted at edge N presents its word on dout after edge N, with dout_valid=1 for one cycle. dout holds that value until the next accepted read.
  - FWFT mode: 0 cycles. dout is the head word combinationally from storage.
- wrerr and rderr are asserted during the cycle after the offending edge.
- Throughput: one write and one read per cycle, sustained, including at full and at empty boundaries (subject to the acceptance rules above).

## Configuration

Macro: MY_SYNC_FIFO_FWFT_EN.

Defined (first-word-fall-through):
- dout shows the word at the read pointer whenever empty=0.
- dout_valid = ~empty.
- rd_en acknowledges and pops that word.
- Storage must support asynchronous read (distributed RAM or registers).
- dout is don't-care while empty=1.

Undefined (standard mode):
- Storage uses a synchronous read port, so block RAM can be inferred.
- dout is registered and updates only on an accepted read.

## Test plan

All scenarios use WIDTH=9, DEPTH_LOG2=4, AFULL_OFFSET=2, AEMPTY_OFFSET=2.

- **Reset then fill:** hold rstn=0 for 2 cycles, then write 0x000..0x00F on 16 consecutive cycles.
  - count steps 1..16.
  - almostempty falls when count reaches 3.
  - almostfull rises at count 14.
  - full rises at 16.
  - A 17th write leaves count=16 and gives wrerr=1 for one cycle.
- **Drain in order:** from full, assert rd_en for 17 cycles.
  - Standard mode: dout=0x000..0x00F on the cycles after each read, with dout_valid pulses.
  - empty=1 after the 16th read.
  - The 17th read gives rderr=1, and dout holds 0x00F.
- **Simultaneous read and write at full:** wr_en=rd_en=1 with din=0x1AA.
  - Both are accepted, count stays 16 and full stays 1.
  - The last word read out after the full drain is 0x1AA.
- **Simultaneous at empty:** wr_en=rd_en=1 while empty.
  - The write is accepted and the read is rejected: count=1 and rderr=1.
  - The next-cycle read returns the written word.
- **Wrap-around:** run 40 cycles of interleaved writes and reads keeping count between 3 and 9.
  - Output matches a scoreboard across pointer wrap with no flag glitches.
- **Reset mid-operation:** with count=7, pulse rstn=0 for 1 cycle while wr_en=1.
  - Next cycle: count=0, empty=1, no error flags, and the write is ignored.
- **FWFT build (MY_SYNC_FIFO_FWFT_EN):** write 0x155 into an empty FIFO.
  - The next cycle shows dout=0x155 and dout_valid=1 with no rd_en.
  - rd_en for one cycle then gives empty=1.

Source files
------------

// File: rtl/my_sync_fifo.sv
// Single-clock parameterised FIFO with threshold flags, occupancy count and error flags.
// Define MY_SYNC_FIFO_FWFT_EN for first-word-fall-through; otherwise dout is registered (1-cycle latency).
module my_sync_fifo #(
    parameter int WIDTH         = 9,
    parameter int DEPTH_LOG2    = 4,
    parameter int AFULL_OFFSET  = 2,
    parameter int AEMPTY_OFFSET = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  wrerr,
    output logic                  rderr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] DEPTH_LEVEL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LEVEL  = CW'(DEPTH - AFULL_OFFSET);
    localparam logic [CW-1:0] AEMPTY_LEVEL = CW'(AEMPTY_OFFSET);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  rd_ok;
    logic                  wr_ok;
    logic [CW-1:0]         count_next;

    // A write into a full FIFO is legal only when a read frees a slot in the same cycle.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        rd_ok      = rd_en & ~empty;
        wr_ok      = wr_en & (~full | rd_ok);
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count - CW'(1);
        end
    end

    // NOTE: storage has no reset; pointers and count define validity, and leaving it unreset keeps RAM inference possible.
    always_ff @(posedge clk) begin
        if (rstn && wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almostfull  <= 1'b0;
            almostempty <= 1'b1;
            wrerr       <= 1'b0;
            rderr       <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count_next;
            full        <= (count_next == DEPTH_LEVEL);
            empty       <= (count_next == '0);
            almostfull  <= (count_next >= AFULL_LEVEL);
            almostempty <= (count_next <= AEMPTY_LEVEL);
            wrerr       <= wr_en & ~wr_ok;
            rderr       <= rd_en & ~rd_ok;
        end
    end

`ifdef MY_SYNC_FIFO_FWFT_EN
    // Head word falls through combinationally; zeroed while empty so dout is clean after reset.
    assign dout       = empty ? '0 : mem[rd_ptr];
    assign dout_valid = ~empty;
`else
    // Synchronous read port: at full, a simultaneous write to the same slot returns the old word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_ok;
            if (rd_ok) begin
                dout <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_my_sync_fifo.sv
// Self-checking bench for my_sync_fifo: directed scenarios plus random traffic against a queue model.
// Works in both the standard and MY_SYNC_FIFO_FWFT_EN builds.
module tb_my_sync_fifo;

    localparam int WIDTH = 9;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int AFO   = 2;
    localparam int AEO   = 2;

    logic             clk = 1'b0;
    logic             rstn;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic             almostfull;
    logic             almostempty;
    logic [DL:0]      count;
    logic             wrerr;
    logic             rderr;

    always #5 clk = ~clk;

    my_sync_fifo #(
        .WIDTH(WIDTH), .DEPTH_LOG2(DL), .AFULL_OFFSET(AFO), .AEMPTY_OFFSET(AEO)
    ) dut (
        .clk(clk), .rstn(rstn), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almostfull(almostfull), .almostempty(almostempty), .count(count),
        .wrerr(wrerr), .rderr(rderr)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a queue of stored words plus the expected registered outputs.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout  = '0;
    logic             exp_valid = 1'b0;
    logic             exp_wrerr = 1'b0;
    logic             exp_rderr = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("count",       64'(count),       64'(q.size()));
        check("empty",       64'(empty),       64'(q.size() == 0));
        check("full",        64'(full),        64'(q.size() == DEPTH));
        check("almostfull",  64'(almostfull),  64'(q.size() >= DEPTH - AFO));
        check("almostempty", 64'(almostempty), 64'(q.size() <= AEO));
        check("wrerr",       64'(wrerr),       64'(exp_wrerr));
        check("rderr",       64'(rderr),       64'(exp_rderr));
`ifdef MY_SYNC_FIFO_FWFT_EN
        check("dout_valid",  64'(dout_valid),  64'(q.size() != 0));
        if (q.size() != 0) begin
            check("dout_head", 64'(dout), 64'(q[0]));
        end
`else
        check("dout_valid",  64'(dout_valid),  64'(exp_valid));
        check("dout",        64'(dout),        64'(exp_dout));
`endif
    endtask

    // Drive one cycle, advance the model at the edge, then compare #1 after the edge.
    task automatic step(input logic r_n, input logic w, input logic r, input logic [WIDTH-1:0] d);
        @(negedge clk);
        rstn  = r_n;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        if (!r_n) begin
            q.delete();
            exp_dout  = '0;
            exp_valid = 1'b0;
            exp_wrerr = 1'b0;
            exp_rderr = 1'b0;
        end else begin
            bit ra;
            bit wa;
            ra        = r && (q.size() > 0);
            wa        = w && ((q.size() < DEPTH) || ra);
            exp_valid = ra;
            exp_rderr = r && !ra;
            exp_wrerr = w && !wa;
            if (ra) exp_dout = q.pop_front();
            if (wa) q.push_back(d);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        logic w;
        logic r;
        rstn  = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;

        // Reset then fill 0x000..0x00F, then a rejected 17th write.
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, WIDTH'(i));
        step(1'b1, 1'b1, 1'b0, 9'h1FF);
        step(1'b1, 1'b0, 1'b0, '0);

        // Drain in order with one extra, rejected read.
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b0, 1'b1, '0);
`ifndef MY_SYNC_FIFO_FWFT_EN
        check("drain_hold", 64'(dout), 64'h00F);
`endif

        // Refill, then simultaneous read and write at full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        step(1'b1, 1'b1, 1'b1, 9'h1AA);
        check("sim_full_count", 64'(count), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, '0);
`ifndef MY_SYNC_FIFO_FWFT_EN
        check("last_word", 64'(dout), 64'h1AA);
`endif

        // Simultaneous at empty: write accepted, read rejected, then read back.
        step(1'b1, 1'b1, 1'b1, 9'h0AB);
        step(1'b1, 1'b0, 1'b1, '0);

        // Wrap-around with occupancy held between 3 and 9.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom);
            r = 1'($urandom);
            if (q.size() >= 9) w = 1'b0;
            if (q.size() <= 3) r = 1'b0;
            step(1'b1, w, r, WIDTH'($urandom));
        end

        // Reset mid-operation at count 7 with a write pending.
        for (int i = 0; i < DEPTH && q.size() < 7; i++) step(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        for (int i = 0; i < DEPTH && q.size() > 7; i++) step(1'b1, 1'b0, 1'b1, '0);
        step(1'b0, 1'b1, 1'b0, 9'h1FF);
        step(1'b1, 1'b0, 1'b0, '0);

        // Single word into an empty FIFO, observed without rd_en, then popped.
        step(1'b1, 1'b1, 1'b0, 9'h155);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, '0);

        // Unconstrained random traffic including overflow and underflow attempts.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), WIDTH'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
